// File: rtl/i2s_mic_array_tx.sv
// -----------------------------------------------------------------------------
// i2s_mic_array_tx
//
// I2S clock-master source that emulates a 16-microphone array. Once per lr_clk
// period it sends one 16-channel PCM frame on 8 data lines, two mics per line
// (left slot = mic 2n, right slot = mic 2n+1). The format is standard I2S: MSB
// first, one bit_clk of delay after each lr_clk edge, and each sample
// left-justified in a SLOT_W-bit slot.
//
// Frames enter through a one-deep holding register with a valid/ready
// handshake. At each frame boundary the holding register is copied into the
// shadow register, and the shadow register is what gets serialised.
//
// Optional build macro:
//   I2S_TX_REPEAT_ON_UNDERRUN_EN - if holding is empty at a boundary, shadow
//                                  keeps its contents and the last frame is
//                                  sent again. Without the macro a zero frame
//                                  is sent. The underrun pulse fires either way.
//
// Ports:
//   clk, rst_n     system clock, asynchronous active-low reset
//   en             run enable (0 lets the current frame finish, then idles)
//   in_valid       a frame is offered on in_data
//   in_ready       holding register empty
//   in_data        16 samples; mic k at [k*SAMPLE_W +: SAMPLE_W]
//   bit_clk        serial bit clock, period 2*CLK_DIV clk cycles
//   lr_clk         word select: 0 = left slot, 1 = right slot
//   sd[7:0]        serial data, one line per mic pair
//   frame_strobe   one-clk pulse at every frame boundary
//   underrun       one-clk pulse when a boundary finds holding empty
// -----------------------------------------------------------------------------
module i2s_mic_array_tx #(
  parameter int SAMPLE_W = 24,
  parameter int SLOT_W   = 32,
  parameter int CLK_DIV  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [16*SAMPLE_W-1:0] in_data,
  output logic                   bit_clk,
  output logic                   lr_clk,
  output logic [7:0]             sd,
  output logic                   frame_strobe,
  output logic                   underrun
);

  localparam int DATA_W  = 16 * SAMPLE_W;
  localparam int FRAME_W = 2 * SLOT_W;
  localparam int BIT_W   = $clog2(FRAME_W);
  localparam int DIV_W   = $clog2(CLK_DIV);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state_r;
  logic [DIV_W-1:0]  div_cnt_r;
  logic              bit_clk_r;
  logic [BIT_W-1:0]  bit_idx_r;
  logic              lr_clk_r;
  logic [7:0]        sd_r;
  logic              frame_strobe_r;
  logic              underrun_r;
  logic              in_ready_r;
  logic              hold_full_r;
  logic [DATA_W-1:0] hold_r;
  logic [DATA_W-1:0] shadow_r;

  logic              div_tc_s;
  logic              fall_s;
  logic              wrap_s;
  logic              start_s;
  logic              stop_s;
  logic              boundary_s;
  logic              take_s;
  logic              hold_full_next_s;
  logic [7:0]        sd_fall_s;
  logic [7:0]        sd_start_s;

  // Return serial bit idx (0 = first bit after the lr_clk edge) of the
  // {L,R} word pair on data line 'line'. Slot bits past SAMPLE_W are padding.
  function automatic logic serial_bit(input logic [DATA_W-1:0] frm,
                                      input int line, input int idx);
    logic [SAMPLE_W-1:0] word_v;
    int                  mic_v;
    int                  pos_v;
    logic                bit_v;
    if (idx >= SLOT_W) begin
      mic_v = 2 * line + 1;
      pos_v = idx - SLOT_W;
    end else begin
      mic_v = 2 * line;
      pos_v = idx;
    end
    word_v = SAMPLE_W'(frm >> (mic_v * SAMPLE_W));
    word_v = word_v << pos_v;
    if (pos_v < SAMPLE_W) begin
      bit_v = word_v[SAMPLE_W-1];
    end else begin
      bit_v = 1'b0;
    end
    return bit_v;
  endfunction

  // On the bit_clk fall that moves b to b+1, the line must carry serial bit b.
  // The boundary fall uses b = FRAME_W-1, which is the last bit of R (still
  // read from the outgoing shadow). A start from IDLE also repeats the last
  // bit of the previous frame.
  for (genvar n = 0; n < 8; n++) begin : g_line
    assign sd_fall_s[n]  = serial_bit(shadow_r, n, int'(bit_idx_r));
    assign sd_start_s[n] = serial_bit(shadow_r, n, FRAME_W - 1);
  end

  // Divider terminal count and frame-position events.
  always_comb begin
    div_tc_s   = (div_cnt_r == DIV_W'(CLK_DIV - 1));
    fall_s     = (state_r != IDLE) && div_tc_s && bit_clk_r;
    wrap_s     = fall_s && (bit_idx_r == BIT_W'(FRAME_W - 1));
    start_s    = (state_r == IDLE) && en;
    stop_s     = wrap_s && (state_r == DRAIN) && !en;
    boundary_s = start_s || (wrap_s && !stop_s);
    take_s     = in_valid && in_ready_r;
  end

  // Holding-register occupancy. A take and a boundary can only coincide while
  // holding is empty, so the new frame stays in holding for the next boundary.
  always_comb begin
    if (take_s) begin
      hold_full_next_s = 1'b1;
    end else if (boundary_s) begin
      hold_full_next_s = 1'b0;
    end else begin
      hold_full_next_s = hold_full_r;
    end
  end

  // Input handshake, holding register and shadow register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_r      <= {DATA_W{1'b0}};
      hold_full_r <= 1'b0;
      in_ready_r  <= 1'b1;
      shadow_r    <= {DATA_W{1'b0}};
    end else begin
      hold_full_r <= hold_full_next_s;
      in_ready_r  <= !hold_full_next_s;
      if (take_s) begin
        hold_r <= in_data;
      end
      if (boundary_s) begin
        if (hold_full_r) begin
          shadow_r <= hold_r;
        end else begin
`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
          shadow_r <= shadow_r;
`else
          shadow_r <= {DATA_W{1'b0}};
`endif
        end
      end
    end
  end

  // Frame sequencer: run state, bit_clk divider, bit index and serial outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= IDLE;
      div_cnt_r      <= {DIV_W{1'b0}};
      bit_clk_r      <= 1'b0;
      bit_idx_r      <= {BIT_W{1'b0}};
      lr_clk_r       <= 1'b0;
      sd_r           <= 8'h00;
      frame_strobe_r <= 1'b0;
      underrun_r     <= 1'b0;
    end else begin
      frame_strobe_r <= 1'b0;
      underrun_r     <= 1'b0;
      case (state_r)
        IDLE: begin
          div_cnt_r <= {DIV_W{1'b0}};
          bit_clk_r <= 1'b0;
          bit_idx_r <= {BIT_W{1'b0}};
          lr_clk_r  <= 1'b0;
          if (start_s) begin
            state_r        <= RUN;
            frame_strobe_r <= 1'b1;
            underrun_r     <= !hold_full_r;
            sd_r           <= sd_start_s;
          end else begin
            state_r <= IDLE;
            sd_r    <= 8'h00;
          end
        end
        RUN, DRAIN: begin
          if (div_tc_s) begin
            div_cnt_r <= {DIV_W{1'b0}};
            bit_clk_r <= !bit_clk_r;
          end else begin
            div_cnt_r <= div_cnt_r + DIV_W'(1);
          end
          if (stop_s) begin
            // The draining frame is complete: go quiet without a new boundary.
            state_r   <= IDLE;
            bit_idx_r <= {BIT_W{1'b0}};
            lr_clk_r  <= 1'b0;
            sd_r      <= 8'h00;
          end else if (wrap_s) begin
            state_r        <= en ? RUN : DRAIN;
            bit_idx_r      <= {BIT_W{1'b0}};
            lr_clk_r       <= 1'b0;
            sd_r           <= sd_fall_s;
            frame_strobe_r <= 1'b1;
            underrun_r     <= !hold_full_r;
          end else if (fall_s) begin
            state_r   <= en ? RUN : DRAIN;
            bit_idx_r <= bit_idx_r + BIT_W'(1);
            lr_clk_r  <= (bit_idx_r >= BIT_W'(SLOT_W - 1));
            sd_r      <= sd_fall_s;
          end else begin
            state_r <= en ? RUN : DRAIN;
          end
        end
        default: begin
          state_r   <= IDLE;
          div_cnt_r <= {DIV_W{1'b0}};
          bit_clk_r <= 1'b0;
          bit_idx_r <= {BIT_W{1'b0}};
          lr_clk_r  <= 1'b0;
          sd_r      <= 8'h00;
        end
      endcase
    end
  end

  assign in_ready     = in_ready_r;
  assign bit_clk      = bit_clk_r;
  assign lr_clk       = lr_clk_r;
  assign sd           = sd_r;
  assign frame_strobe = frame_strobe_r;
  assign underrun     = underrun_r;

endmodule

// File: tb/tb_i2s_mic_array_tx.sv
// -----------------------------------------------------------------------------
// tb_i2s_mic_array_tx
//
// Directed testbench for i2s_mic_array_tx with SAMPLE_W=24, SLOT_W=32 and
// CLK_DIV=2. The expected serial words below were worked out by hand. A line
// word {L,R} is delayed by one bit and b=0 carries the previous frame's last
// bit. The cap[] arrays are ordered so that cap[n][63-b] is the value on
// sd[n] during bit b.
// -----------------------------------------------------------------------------
module tb_i2s_mic_array_tx;

  localparam int SW = 24;
  localparam int DW = 16 * SW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          bit_clk;
  logic          lr_clk;
  logic [7:0]    sd;
  logic          frame_strobe;
  logic          underrun;

  int            total = 0;
  int            bad = 0;
  int            cyc = 0;
  logic [63:0]   cap [0:7];

  i2s_mic_array_tx #(.SAMPLE_W(SW), .SLOT_W(32), .CLK_DIV(2)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .bit_clk(bit_clk),
    .lr_clk(lr_clk), .sd(sd), .frame_strobe(frame_strobe),
    .underrun(underrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic wait_strobe(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (frame_strobe === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_falls(input int n, output bit ok);
    int   seen;
    logic prev;
    seen = 0;
    prev = bit_clk;
    for (int i = 0; i < 600 && seen < n; i++) begin
      @(negedge clk);
      if (prev === 1'b1 && bit_clk === 1'b0) seen++;
      prev = bit_clk;
    end
    ok = (seen == n);
  endtask

  task automatic capture_frame(output bit ok);
    int   rises;
    logic prev;
    rises = 0;
    prev = bit_clk;
    for (int n = 0; n < 8; n++) cap[n] = 64'd0;
    for (int i = 0; i < 600 && rises < 64; i++) begin
      @(negedge clk);
      if (bit_clk === 1'b1 && prev === 1'b0) begin
        for (int n = 0; n < 8; n++) cap[n][63 - rises] = sd[n];
        rises++;
      end
      prev = bit_clk;
    end
    ok = (rises == 64);
  endtask

  task automatic load_frame(input logic [DW-1:0] f, output bit ok);
    ok = 1'b0;
    in_data = f;
    in_valid = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if (in_ready === 1'b1) begin
        ok = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if ({bit_clk, lr_clk, frame_strobe, underrun} !== 4'b0000) begin bad++; $display("FAIL reset_ctl got=%b exp=0000", {bit_clk, lr_clk, frame_strobe, underrun}); end
    total++; if (sd !== 8'h00) begin bad++; $display("FAIL reset_sd got=%h exp=00", sd); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    total++; if ({bit_clk, lr_clk, frame_strobe, sd} !== 11'd0) begin bad++; $display("FAIL idle_quiet got=%h exp=0", {bit_clk, lr_clk, frame_strobe, sd}); end
  endtask

  task automatic test_first_frames();
    bit            ok;
    logic [DW-1:0] f;
    logic [63:0]   any;
    en = 1'b1;
    wait_strobe(ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL start_strobe got=timeout exp=strobe"); end
    total++; if (underrun !== 1'b1) begin bad++; $display("FAIL start_underrun got=%b exp=1", underrun); end
    f = '0;
    f[0 +: SW] = 24'h800001;
    f[SW +: SW] = 24'h7FFFFF;
    load_frame(f, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL load1 got=timeout exp=accept"); end
    capture_frame(ok);
    any = 64'd0;
    for (int n = 0; n < 8; n++) any = any | cap[n];
    total++; if (ok !== 1'b1 || any !== 64'd0) begin bad++; $display("FAIL frame1_zero got=%h ok=%b exp=0", any, ok); end
    wait_strobe(ok);
    total++; if (ok !== 1'b1 || underrun !== 1'b0) begin bad++; $display("FAIL frame2_strobe got=ok%b/ur%b exp=ok1/ur0", ok, underrun); end
    capture_frame(ok);
    total++; if (ok !== 1'b1 || cap[0] !== 64'h40000080_3FFFFF80) begin bad++; $display("FAIL frame2_sd0 got=%h exp=400000803fffff80", cap[0]); end
    any = 64'd0;
    for (int n = 1; n < 8; n++) any = any | cap[n];
    total++; if (any !== 64'd0) begin bad++; $display("FAIL frame2_other got=%h exp=0", any); end
  endtask

  task automatic test_clock();
    int   rise_t [0:1];
    int   fall_t;
    int   nr;
    int   lr_t [0:1];
    int   nl;
    logic prev;
    logic prev_lr;
    bit   aligned;
    nr = 0;
    fall_t = 0;
    rise_t[0] = 0;
    rise_t[1] = 0;
    prev = bit_clk;
    for (int i = 0; i < 40 && nr < 2; i++) begin
      @(negedge clk);
      if (bit_clk === 1'b1 && prev === 1'b0) begin
        rise_t[nr] = cyc;
        nr++;
      end
      if (bit_clk === 1'b0 && prev === 1'b1 && nr == 1) fall_t = cyc;
      prev = bit_clk;
    end
    total++; if (nr != 2 || rise_t[1] - rise_t[0] != 4) begin bad++; $display("FAIL bclk_period got=%0d exp=4", rise_t[1] - rise_t[0]); end
    total++; if (fall_t - rise_t[0] != 2) begin bad++; $display("FAIL bclk_high got=%0d exp=2", fall_t - rise_t[0]); end
    nl = 0;
    lr_t[0] = 0;
    lr_t[1] = 0;
    aligned = 1'b1;
    prev_lr = lr_clk;
    prev = bit_clk;
    for (int i = 0; i < 400 && nl < 2; i++) begin
      @(negedge clk);
      if (lr_clk !== prev_lr) begin
        lr_t[nl] = cyc;
        nl++;
        if (!(prev === 1'b1 && bit_clk === 1'b0)) aligned = 1'b0;
      end
      prev_lr = lr_clk;
      prev = bit_clk;
    end
    total++; if (nl != 2 || lr_t[1] - lr_t[0] != 128) begin bad++; $display("FAIL lr_half_period got=%0d exp=128", lr_t[1] - lr_t[0]); end
    total++; if (nl != 2 || aligned !== 1'b1) begin bad++; $display("FAIL lr_align got=%b exp=1", aligned); end
  endtask

  task automatic test_back_to_back();
    bit            ok;
    logic [DW-1:0] fa;
    logic [DW-1:0] fb;
    fa = '0;
    fa[0 +: SW] = 24'hABCDEF;
    fa[SW +: SW] = 24'h000001;
    fa[15*SW +: SW] = 24'hFFFFFF;
    fb = '0;
    fb[0 +: SW] = 24'h800000;
    fb[2*SW +: SW] = 24'h5A5A5A;
    wait_strobe(ok);
    total++; if (ok !== 1'b1 || in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_a got=ok%b/rdy%b exp=ok1/rdy1", ok, in_ready); end
    in_data = fa;
    in_valid = 1'b1;
    @(negedge clk);
    in_data = fb;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_ready_drop got=%b exp=0", in_ready); end
    wait_strobe(ok);
    total++; if (ok !== 1'b1 || underrun !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL b2b_boundary_a got=ok%b/ur%b/rdy%b exp=1/0/1", ok, underrun, in_ready); end
    @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_take_b got=%b exp=0", in_ready); end
    in_valid = 1'b0;
    capture_frame(ok);
    total++; if (ok !== 1'b1 || cap[0] !== 64'h55E6F780_00000080) begin bad++; $display("FAIL b2b_a_sd0 got=%h exp=55e6f78000000080", cap[0]); end
    total++; if (cap[7] !== 64'h00000000_7FFFFF80 || cap[1] !== 64'd0) begin bad++; $display("FAIL b2b_a_sd7 got=%h/%h exp=000000007fffff80/0", cap[7], cap[1]); end
    wait_strobe(ok);
    total++; if (ok !== 1'b1 || underrun !== 1'b0) begin bad++; $display("FAIL b2b_boundary_b got=ok%b/ur%b exp=1/0", ok, underrun); end
    capture_frame(ok);
    total++; if (ok !== 1'b1 || cap[0] !== 64'h40000000_00000000) begin bad++; $display("FAIL b2b_b_sd0 got=%h exp=4000000000000000", cap[0]); end
    total++; if (cap[1] !== 64'h2D2D2D00_00000000) begin bad++; $display("FAIL b2b_b_sd1 got=%h exp=2d2d2d0000000000", cap[1]); end
  endtask

  task automatic test_drain();
    bit   ok;
    int   falls;
    int   strobes;
    logic prev;
    wait_strobe(ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL drain_strobe got=timeout exp=strobe"); end
    wait_falls(20, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL drain_b20 got=timeout exp=20 falls"); end
    en = 1'b0;
    falls = 0;
    strobes = 0;
    prev = bit_clk;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (prev === 1'b1 && bit_clk === 1'b0) falls++;
      if (frame_strobe === 1'b1) strobes++;
      prev = bit_clk;
    end
    total++; if (falls != 44) begin bad++; $display("FAIL drain_falls got=%0d exp=44", falls); end
    total++; if (strobes != 0) begin bad++; $display("FAIL drain_strobes got=%0d exp=0", strobes); end
    total++; if ({bit_clk, lr_clk, sd} !== 10'd0) begin bad++; $display("FAIL drain_idle got=%h exp=0", {bit_clk, lr_clk, sd}); end
  endtask

  task automatic test_reset_midframe();
    bit            ok;
    logic [DW-1:0] f;
    int            n;
    logic          prev;
    en = 1'b1;
    wait_strobe(ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL rst_run_strobe got=timeout exp=strobe"); end
    f = '0;
    f[0 +: SW] = 24'hC0FFEE;
    load_frame(f, ok);
    wait_falls(40, ok);
    repeat (2) @(negedge clk);
    total++; if (ok !== 1'b1 || lr_clk !== 1'b1 || bit_clk !== 1'b1 || in_ready !== 1'b0) begin bad++; $display("FAIL rst_pre got=lr%b/bc%b/rdy%b exp=1/1/0", lr_clk, bit_clk, in_ready); end
    #1 rst_n = 1'b0;
    #1;
    total++; if ({bit_clk, lr_clk, sd, frame_strobe, underrun} !== 12'd0) begin bad++; $display("FAIL rst_async got=%h exp=0", {bit_clk, lr_clk, sd, frame_strobe, underrun}); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_async_ready got=%b exp=1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    wait_strobe(ok);
    total++; if (ok !== 1'b1 || underrun !== 1'b1) begin bad++; $display("FAIL rst_restart got=ok%b/ur%b exp=1/1", ok, underrun); end
    n = 0;
    prev = bit_clk;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n++;
      if (prev === 1'b1 && bit_clk === 1'b0) break;
      prev = bit_clk;
    end
    total++; if (n != 4 || lr_clk !== 1'b0) begin bad++; $display("FAIL rst_b0 got=%0d/lr%b exp=4/0", n, lr_clk); end
  endtask

  task automatic test_underrun();
    bit            ok;
    logic [DW-1:0] f;
    logic [63:0]   exp_rep;
    f = '0;
    f[0 +: SW] = 24'h123456;
    load_frame(f, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL ur_load got=timeout exp=accept"); end
    wait_strobe(ok);
    total++; if (ok !== 1'b1 || underrun !== 1'b0) begin bad++; $display("FAIL ur_first got=ok%b/ur%b exp=1/0", ok, underrun); end
    capture_frame(ok);
    total++; if (ok !== 1'b1 || cap[0] !== 64'h091A2B00_00000000) begin bad++; $display("FAIL ur_sent got=%h exp=091a2b0000000000", cap[0]); end
    wait_strobe(ok);
    total++; if (ok !== 1'b1 || underrun !== 1'b1) begin bad++; $display("FAIL ur_pulse got=ok%b/ur%b exp=1/1", ok, underrun); end
    capture_frame(ok);
`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
    exp_rep = 64'h091A2B00_00000000;
`else
    exp_rep = 64'h00000000_00000000;
`endif
    total++; if (ok !== 1'b1 || cap[0] !== exp_rep) begin bad++; $display("FAIL ur_frame got=%h exp=%h", cap[0], exp_rep); end
  endtask

  initial begin
    test_reset();
    test_first_frames();
    test_clock();
    test_back_to_back();
    test_drain();
    test_reset_midframe();
    test_underrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
